fpga_rom_bram_arbiter: RTL

// - Shares the single Caliptra ROM BRAM port between NUM_REQ requesters: SoC AXI BRAM path and internal ROM loader/scrubber.
// - Uses round-robin arbitration, one access per cycle, with a registered BRAM command stage.
// - Read responses return in order, with fixed latency, to the issuing requester.
// - Sits in the FPGA wrapper between the requesters and the ROM BRAM (14-bit word address, 32-bit data, 4 byte enables).

---
 rtl/fpga_rom_arb_pkg.sv | 24 ++
 rtl/fpga_rom_bram_arbiter_rr.sv | 44 ++++
 rtl/fpga_rom_bram_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/fpga_rom_arb_pkg.sv
// Shared types and default sizes for the ROM BRAM arbiter.
// Tag entries follow each accepted access down the pipeline to its response.
package fpga_rom_arb_pkg;

    localparam int ROM_ADDR_W = 14;
    localparam int ROM_DATA_W = 32;
    localparam int ROM_RD_LAT = 1;
    localparam int BE_W       = ROM_DATA_W / 8;
    localparam int TAG_DEPTH  = 1 + ROM_RD_LAT;

    typedef struct packed {
        logic       valid;
        logic [1:0] id;
        logic       is_read;
        logic       err;
    } rom_tag_t;

    typedef struct packed {
        logic [BE_W-1:0]       we;
        logic [ROM_ADDR_W-1:0] addr;
        logic [ROM_DATA_W-1:0] wdata;
    } rom_cmd_t;

endpackage

// File: rtl/fpga_rom_bram_arbiter_rr.sv
// Round-robin grant for NUM_REQ requesters; the pointer moves past each winner
// and holds when nothing is granted.
module fpga_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_valid,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [1:0]         o_gnt_id
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_found;
    int               v_idx;

    always_comb begin
        o_grant   = '0;
        o_gnt_id  = '0;
        w_ptr_nxt = r_ptr;
        w_found   = 1'b0;
        v_idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && i_valid[v_idx]) begin
                w_found          = 1'b1;
                o_grant[v_idx]   = 1'b1;
                o_gnt_id         = 2'(v_idx);
                w_ptr_nxt        = PTR_W'((v_idx + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/fpga_rom_bram_arbiter.sv
// Shares one ROM BRAM port between NUM_REQ requesters with in-order, fixed-latency responses.
// Optional write lock is built only when FPGA_ROM_WR_LOCK_EN is defined.
module fpga_rom_bram_arbiter
    import fpga_rom_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = ROM_ADDR_W,
    parameter int DATA_W      = ROM_DATA_W,
    parameter int BRAM_RD_LAT = ROM_RD_LAT
) (
    input  logic                      core_clk,
    input  logic                      S_AXI_ARESETN,
    input  logic [NUM_REQ-1:0]        rq_valid,
    output logic [NUM_REQ-1:0]        rq_ready,
    input  logic [NUM_REQ*BE_W-1:0]   rq_we,
    input  logic [NUM_REQ*ADDR_W-1:0] rq_addr,
    input  logic [NUM_REQ*DATA_W-1:0] rq_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    input  logic                      rom_wr_lock,
    output logic                      bram_en,
    output logic [BE_W-1:0]           bram_we,
    output logic [ADDR_W-1:0]         bram_addr,
    output logic [DATA_W-1:0]         bram_wrdata,
    input  logic [DATA_W-1:0]         bram_rddata
);
    localparam int DEPTH = 1 + BRAM_RD_LAT;

    logic [NUM_REQ-1:0] w_grant;
    logic [1:0]         w_gnt_id;
    logic               w_acc;
    logic [BE_W-1:0]    w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_is_read;
    logic               w_sup;
    logic               w_issue;
    rom_tag_t           r_tag [DEPTH];
    rom_tag_t           w_rsp;

    fpga_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk      (core_clk),
        .rst_n    (S_AXI_ARESETN),
        .i_valid  (rq_valid),
        .o_grant  (w_grant),
        .o_gnt_id (w_gnt_id)
    );

    assign rq_ready  = w_grant & {NUM_REQ{S_AXI_ARESETN}};
    assign w_acc     = |w_grant;
    assign w_we      = rq_we[w_gnt_id*BE_W +: BE_W];
    assign w_addr    = rq_addr[w_gnt_id*ADDR_W +: ADDR_W];
    assign w_wdata   = rq_wdata[w_gnt_id*DATA_W +: DATA_W];
    assign w_is_read = (w_we == '0);

`ifdef FPGA_ROM_WR_LOCK_EN
    // Locked writes still handshake and respond, but never reach the BRAM.
    assign w_sup = w_acc & ~w_is_read & rom_wr_lock;
`else
    assign w_sup = 1'b0;
`endif
    assign w_issue = w_acc & ~w_sup;

    always_ff @(posedge core_clk or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            bram_en     <= 1'b0;
            bram_we     <= '0;
            bram_addr   <= '0;
            bram_wrdata <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            bram_en <= w_issue;
            bram_we <= w_issue ? w_we : '0;
            if (w_issue) begin
                bram_addr   <= w_addr;
                bram_wrdata <= w_wdata;
            end
            r_tag[0] <= '{valid: w_acc, id: w_gnt_id, is_read: w_is_read, err: w_sup};
            for (int k = 1; k < DEPTH; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign w_rsp = r_tag[BRAM_RD_LAT];

    always_comb begin
        rsp_valid = '0;
        if (w_rsp.valid) begin
            rsp_valid[w_rsp.id] = 1'b1;
        end
    end

    assign rsp_rdata = (w_rsp.valid && w_rsp.is_read) ? bram_rddata : '0;

`ifdef FPGA_ROM_WR_LOCK_EN
    assign rsp_err = w_rsp.valid & w_rsp.err;
`else
    logic w_unused_lock;
    assign w_unused_lock = ^{rom_wr_lock, w_rsp.err};
    assign rsp_err       = 1'b0;
`endif

endmodule
